cache_bus_arbiter: RTL and testbench
====================================

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, meaning words per cache-line burst (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports ic_req input 1 (iCache refill request) and ic_addr input ADDR_W (line base address).
REQ-007 SHALL have ports ic_rvalid output 1, ic_rdata output DATA_W, ic_done output 1 (read beat and burst completion).
REQ-008 SHALL have ports dc_req input 1, dc_we input 1 (1 = writeback), dc_addr input ADDR_W, dc_wdata input DATA_W.
REQ-009 SHALL have ports dc_rvalid output 1, dc_rdata output DATA_W, dc_wready output 1, dc_done output 1.
REQ-010 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W.
REQ-011 SHALL have ports mem_ack input 1 (one beat accepted/returned) and mem_rdata input DATA_W.

Function
REQ-012 SHALL implement FSM states IDLE, BURST, DONE.
REQ-013 SHALL, in IDLE, grant when ic_req or dc_req is high; transition to BURST on the next edge with beat counter = 0 and requester, address base and we latched.
REQ-014 SHALL, on simultaneous ic_req and dc_req, grant round-robin: requester not served by the most recent grant wins; after reset, dCache wins first.
REQ-015 SHALL, in BURST, drive mem_req=1, mem_we=latched we (0 for iCache), mem_addr=base+4*beat.
REQ-016 SHALL align base to the line: low log2(BURST_LEN*DATA_W/8) address bits forced to 0.
REQ-017 SHALL increment beat counter on each mem_ack; on mem_ack with beat=BURST_LEN-1 go to DONE.
REQ-018 SHALL, on read bursts, assert the granted requester's rvalid for exactly the mem_ack cycles with rdata=mem_rdata, same cycle (zero latency).
REQ-019 SHALL, on writeback, drive mem_wdata=dc_wdata and dc_wready=mem_ack, so dCache advances its word on dc_wready.
REQ-020 SHALL, in DONE, pulse the granted requester's done for one cycle, drive mem_req=0, then return to IDLE.
REQ-021 SHALL ignore requester deassertion mid-burst; a started burst always runs to BURST_LEN beats.
REQ-022 SHALL require requesters to drop req in the cycle after done; a req still high in IDLE is a new request.
REQ-023 SHALL hold all outputs of the non-granted requester at 0 throughout.
REQ-024 SHALL add no bubble beyond DONE: back-to-back bursts are separated by exactly DONE plus IDLE (2 cycles, mem_req=0).

Reset
REQ-025 SHALL, on reset, enter IDLE, clear beat counter, set round-robin pointer to favour dCache.
REQ-026 SHALL hold all outputs at 0 during and after reset until a grant.
REQ-027 SHALL, on reset mid-burst, abandon the burst immediately with no done pulse.

Configuration
REQ-028 SHALL support macro CACHE_ARB_DCACHE_PRIO_EN.
REQ-029 SHALL, with CACHE_ARB_DCACHE_PRIO_EN defined, always grant dCache on simultaneous requests (fixed priority).
REQ-030 SHALL, without CACHE_ARB_DCACHE_PRIO_EN, use round-robin per REQ-014.

Verification
REQ-031 SHALL test: reset, ic_req=1 addr 0x1000_0014, mem_ack every cycle -> mem_addr 0x1000_0000..0x1000_001C, 8 ic_rvalid, ic_done pulse on cycle 10.
REQ-032 SHALL test: dc_req=1 dc_we=1 addr 0x2000_0040, mem_ack every other cycle -> mem_we=1, 8 dc_wready pulses, dc_done after 16th BURST cycle.
REQ-033 SHALL test: ic_req and dc_req rise together after reset -> dCache served first, iCache second; repeat -> order alternates (round-robin) or dCache always first (macro defined).
REQ-034 SHALL test: reset asserted after beat 3 of a read -> IDLE next cycle, mem_req=0, no done pulse, next burst starts at beat 0.
REQ-035 SHALL test: dc_req dropped at beat 2 -> burst still completes 8 beats and dc_done pulses once.

Source files
------------

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: shares one burst memory port between an iCache (refill
// reads) and a dCache (refill reads and line writebacks). Each grant runs one
// full cache-line burst of BURST_LEN beats, then a one-cycle DONE handshake.
// Simultaneous requests are resolved round-robin, or always in favour of the
// dCache when CACHE_ARB_DCACHE_PRIO_EN is defined.
module cache_bus_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  // iCache refill port
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  // dCache refill / writeback port
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_wready,
  output logic              dc_done,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFFS_W = $clog2(BURST_LEN * DATA_W / 8);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic              gnt_dc;   // 1 = current burst belongs to the dCache
  logic              we_q;     // current burst is a writeback
  logic [ADDR_W-1:0] addr_q;   // address of the beat in flight
  logic              last_dc;  // most recent grant went to the dCache
  logic              pick_dc;
  logic              in_burst;
  logic              in_done;

  // Arbitration: decide who would win if a grant happened this cycle.
  always_comb begin
`ifdef CACHE_ARB_DCACHE_PRIO_EN
    pick_dc = dc_req;
`else
    // The requester not served last time wins a tie; reset leaves last_dc=0
    // so the dCache wins the first tie.
    pick_dc = dc_req && (!ic_req || !last_dc);
`endif
  end

  // Burst sequencer: grant, count beats on mem_ack, pulse done, return to idle.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state   <= IDLE;
      beat    <= '0;
      gnt_dc  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      last_dc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_req || dc_req) begin
            state   <= BURST;
            beat    <= '0;
            gnt_dc  <= pick_dc;
            last_dc <= pick_dc;
            we_q    <= pick_dc && dc_we;
            addr_q  <= (pick_dc ? dc_addr : ic_addr) & LINE_MASK;
          end
        end
        BURST: begin
          // Requests are not looked at here: a started line always completes.
          if (mem_ack) begin
            beat   <= beat + 1'b1;
            addr_q <= addr_q + ADDR_W'(4);
            if (beat == LAST_BEAT) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state plus zero-latency beat pass-through.
  always_comb begin
    // NOTE: reset also masks the outputs combinationally, so a burst that is
    // reset mid-flight drops mem_req and never pulses done in that same cycle.
    in_burst  = (state == BURST) && !reset;
    in_done   = (state == DONE)  && !reset;
    // NOTE: every output gets a value on every path, so no latches are inferred.
    mem_req   = in_burst;
    mem_we    = in_burst && we_q;
    mem_addr  = in_burst ? addr_q : '0;
    mem_wdata = (in_burst && we_q) ? dc_wdata : '0;
    ic_rvalid = in_burst && !gnt_dc && mem_ack;
    ic_rdata  = ic_rvalid ? mem_rdata : '0;
    ic_done   = in_done && !gnt_dc;
    dc_rvalid = in_burst && gnt_dc && !we_q && mem_ack;
    dc_rdata  = dc_rvalid ? mem_rdata : '0;
    dc_wready = in_burst && gnt_dc && we_q && mem_ack;
    dc_done   = in_done && gnt_dc;
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: directed bursts against a small memory
// responder; expected beats and done pulses go into a scoreboard queue that a
// negedge monitor drains, while per-cycle timing is checked by the stimulus.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_rvalid, ic_done;
  logic [31:0] ic_rdata;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata;
  logic        dc_rvalid, dc_wready, dc_done;
  logic [31:0] dc_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  typedef enum logic [2:0] {K_IC_RD, K_DC_RD, K_DC_WR, K_IC_DONE, K_DC_DONE, K_BAD} kind_t;
  typedef struct packed {
    kind_t       kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  bit         ack_every = 1'b1;
  logic [4:0] bcnt = '0;
  logic [3:0] widx = '0;

  always #5 clk = ~clk;

  cache_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_wready(dc_wready), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Memory responder: acks every cycle, or every second cycle of a burst.
  always @(posedge clk) bcnt <= mem_req ? bcnt + 5'd1 : 5'd0;
  assign mem_ack   = mem_req && (ack_every || bcnt[0]);
  assign mem_rdata = mem_req ? (mem_addr ^ 32'h5A5A_0000) : 32'h0;

  // dCache writeback source: advances one word per dc_wready.
  always @(posedge clk) begin
    if (dc_done)        widx <= '0;
    else if (dc_wready) widx <= widx + 4'd1;
  end
  assign dc_wdata = 32'hD000_0000 + {28'h0, widx};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat or done pulse the DUT presents is matched in order.
  always @(negedge clk) begin
    kind_t       k;
    logic [31:0] a, d;
    logic        obs;
    exp_t        e;
    obs = 1'b0; k = K_BAD; a = '0; d = '0;
    if (mem_req && mem_ack) begin
      obs = 1'b1;
      a = mem_addr;
      if (ic_rvalid && !dc_rvalid && !dc_wready && !mem_we) begin
        k = K_IC_RD; d = ic_rdata;
      end else if (dc_rvalid && !ic_rvalid && !dc_wready && !mem_we) begin
        k = K_DC_RD; d = dc_rdata;
      end else if (dc_wready && !ic_rvalid && !dc_rvalid && mem_we) begin
        k = K_DC_WR; d = mem_wdata;
      end
    end else if (ic_done || dc_done) begin
      obs = 1'b1;
      if (ic_done && !dc_done)      k = K_IC_DONE;
      else if (dc_done && !ic_done) k = K_DC_DONE;
    end else if (ic_rvalid || dc_rvalid || dc_wready) begin
      obs = 1'b1;
    end
    if (obs) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got event kind %0d addr %0h, expected nothing (t=%0t)",
                 k, a, $time);
      end else begin
        e = sb.pop_front();
        check("sb_kind", 64'(k), 64'(e.kind));
        check("sb_addr", 64'(a), 64'(e.addr));
        check("sb_data", 64'(d), 64'(e.data));
      end
    end
  end

  function automatic logic any_output();
    return |{ic_rvalid, ic_rdata, ic_done, dc_rvalid, dc_rdata, dc_wready, dc_done,
             mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic push_burst(input bit is_dc, input bit we, input logic [31:0] base,
                            input int nbeats, input bit with_done);
    exp_t e;
    for (int k = 0; k < nbeats; k++) begin
      e.kind = we ? K_DC_WR : (is_dc ? K_DC_RD : K_IC_RD);
      e.addr = base + 32'(4 * k);
      e.data = we ? 32'hD000_0000 + 32'(k) : (e.addr ^ 32'h5A5A_0000);
      sb.push_back(e);
    end
    if (with_done) begin
      e.kind = is_dc ? K_DC_DONE : K_IC_DONE;
      e.addr = '0;
      e.data = '0;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b1;  // must be ignored under reset
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check("reset_outputs", 64'(any_output()), 64'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", 64'(any_output()), 64'd0);
    @(posedge clk); #1;
  endtask

  // One requester, one burst; grant in cycle 1, done in cycle n+2.
  task automatic run_one(input bit is_dc, input bit we, input logic [31:0] addr,
                         input logic [31:0] base, input bit every, input int drop_cyc,
                         input string tag);
    int n, dones, wr, rv;
    n = every ? 8 : 16;
    dones = 0; wr = 0; rv = 0;
    ack_every = every;
    push_burst(is_dc, we, base, 8, 1'b1);
    if (is_dc) begin dc_req = 1'b1; dc_we = we; dc_addr = addr; end
    else       begin ic_req = 1'b1; ic_addr = addr; end
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clk);
      check({tag, "_mem_req"}, 64'(mem_req), 64'(c >= 2 && c <= n + 1));
      check({tag, "_mem_we"}, 64'(mem_we), 64'(we && c >= 2 && c <= n + 1));
      check({tag, "_done"}, 64'(is_dc ? dc_done : ic_done), 64'(c == n + 2));
      check({tag, "_other_done"}, 64'(is_dc ? ic_done : dc_done), 64'd0);
      dones += int'(is_dc ? dc_done : ic_done);
      wr    += int'(dc_wready);
      rv    += int'(is_dc ? dc_rvalid : ic_rvalid);
      @(posedge clk); #1;
      if (c + 1 == drop_cyc) begin ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; end
    end
    check({tag, "_beats"}, 64'(we ? wr : rv), 64'd8);
    check({tag, "_done_count"}, 64'(dones), 64'd1);
  endtask

  // Both requesters rise together; first winner done in cycle 10, second in 20.
  task automatic run_two(input bit dc_first, input string tag);
    ack_every = 1'b1;
    ic_addr = 32'h3000_0004;
    dc_addr = 32'h4000_0020;
    dc_we   = 1'b0;
    if (dc_first) begin
      push_burst(1'b1, 1'b0, 32'h4000_0020, 8, 1'b1);
      push_burst(1'b0, 1'b0, 32'h3000_0000, 8, 1'b1);
    end else begin
      push_burst(1'b0, 1'b0, 32'h3000_0000, 8, 1'b1);
      push_burst(1'b1, 1'b0, 32'h4000_0020, 8, 1'b1);
    end
    ic_req = 1'b1; dc_req = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      check({tag, "_mem_req"}, 64'(mem_req), 64'((c >= 2 && c <= 9) || (c >= 12 && c <= 19)));
      check({tag, "_ic_done"}, 64'(ic_done), 64'(dc_first ? c == 20 : c == 10));
      check({tag, "_dc_done"}, 64'(dc_done), 64'(dc_first ? c == 10 : c == 20));
      @(posedge clk); #1;
      if (c == 10) begin if (dc_first) dc_req = 1'b0; else ic_req = 1'b0; end
      if (c == 20) begin ic_req = 1'b0; dc_req = 1'b0; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset(2);

    // iCache refill from mid-line address, ack every cycle.
    run_one(1'b0, 1'b0, 32'h1000_0014, 32'h1000_0000, 1'b1, 11, "ic_rd");
    // dCache writeback, ack every other cycle.
    run_one(1'b1, 1'b1, 32'h2000_0040, 32'h2000_0040, 1'b0, 19, "dc_wb");

    // Tie-breaking after reset, then a tie after a dCache-only grant.
    do_reset(1);
    run_two(1'b1, "tie_first");
    run_one(1'b1, 1'b0, 32'h4000_0044, 32'h4000_0040, 1'b1, 11, "dc_solo");
`ifdef CACHE_ARB_DCACHE_PRIO_EN
    run_two(1'b1, "tie_prio");
`else
    run_two(1'b0, "tie_rr");
`endif

    // Reset after beat 3 of an iCache read; the held request restarts at beat 0.
    do_reset(1);
    ack_every = 1'b1;
    push_burst(1'b0, 1'b0, 32'h6000_0000, 4, 1'b0);
    push_burst(1'b0, 1'b0, 32'h6000_0000, 8, 1'b1);
    ic_req = 1'b1; ic_addr = 32'h6000_0008;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      check("rst_mid_mem_req", 64'(mem_req), 64'((c >= 2 && c <= 5) || (c >= 8 && c <= 15)));
      check("rst_mid_ic_done", 64'(ic_done), 64'(c == 16));
      if (c == 6 || c == 7) check("rst_mid_outputs", 64'(any_output()), 64'd0);
      @(posedge clk); #1;
      if (c == 5)  reset = 1'b1;
      if (c == 6)  reset = 1'b0;
      if (c == 16) ic_req = 1'b0;
    end

    // dCache drops its request at beat 2; the line still completes.
    run_one(1'b1, 1'b0, 32'h5000_0060, 32'h5000_0060, 1'b1, 4, "dc_drop");

    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
